// File: rtl/fipo_memory_param.sv
// Serial-in/parallel-out configuration memory: collects DATA_W/LANES beats and commits a full word to a shadow output.
// Latency: parallel_out updates on the edge that captures the final beat; end_writing pulses for the cycle after.
// Backpressure: none; beats arriving after a completed load are dropped and flagged on overflow until clear.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   enable       serial_in carries a valid beat this cycle
//   clear        synchronous restart of the current load (wins over enable)
//   serial_in    LANES-bit beat
//   parallel_out last committed complete word
//   end_writing  one-cycle pulse following a commit
//   data_written sticky: a word has been committed since reset
//   busy         load in progress (0 < count < BEATS)
//   overflow     sticky: a beat arrived while the word was complete
//   count        beats captured in the current load
module fipo_memory_param #(
  parameter int DATA_W    = 312,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b1,
  localparam int BEATS    = DATA_W / LANES,
  localparam int CNT_W    = $clog2(BEATS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic [LANES-1:0]  serial_in,
  output logic [DATA_W-1:0] parallel_out,
  output logic              end_writing,
  output logic              data_written,
  output logic              busy,
  output logic              overflow,
  output logic [CNT_W-1:0]  count
);

  if (DATA_W % LANES != 0) begin : g_bad_lanes
    $error("fipo_memory_param: DATA_W must be a multiple of LANES");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic              w_last_beat;

  // Shift register contents after accepting the current beat. A single-beat
  // word simply is the beat, which also avoids an empty slice below.
  if (BEATS == 1) begin : g_one_beat
    assign w_shift_nxt = serial_in;
  end else if (MSB_FIRST) begin : g_msb_first
    assign w_shift_nxt = {r_shift[DATA_W-LANES-1:0], serial_in};
  end else begin : g_lsb_first
    assign w_shift_nxt = {serial_in, r_shift[DATA_W-1:LANES]};
  end

  assign w_last_beat = (count == LAST_CNT);
  assign busy        = (r_state == S_LOAD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      parallel_out <= '0;
      count        <= '0;
      end_writing  <= 1'b0;
      data_written <= 1'b0;
      overflow     <= 1'b0;
    end else if (clear) begin
      // Restart only the in-flight load; the committed word survives.
      r_state     <= S_IDLE;
      r_shift     <= '0;
      count       <= '0;
      end_writing <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      end_writing <= 1'b0;
      if (enable) begin
        if (r_state == S_DONE) begin
          overflow <= 1'b1;
        end else begin
          r_shift <= w_shift_nxt;
          count   <= count + 1'b1;
          if (w_last_beat) begin
            // Commit includes the beat captured on this very edge.
            parallel_out <= w_shift_nxt;
            r_state      <= S_DONE;
            end_writing  <= 1'b1;
            data_written <= 1'b1;
          end else begin
            r_state <= S_LOAD;
          end
        end
      end
    end
  end

endmodule
